// File: rtl/nou_sched_pkg.sv
// Shared types and sizes for the NOU request scheduler.
// Class encoding doubles as the engine payload-mux select.
package nou_sched_pkg;

    localparam int NOU_REQ_CLS_NUM = 4;
    localparam int NOU_CNT_W       = 8;

    typedef enum logic [1:0] {
        CLS_IRR  = 2'd0,
        CLS_BRR  = 2'd1,
        CLS_PWRR = 2'd2,
        CLS_SPRR = 2'd3
    } nou_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } nou_state_e;

endpackage

// File: rtl/nou_rr_arb.sv
// Four-way combinational round-robin pick over the pending classes.
// The search starts at rr_ptr and walks upward modulo 4.
module nou_rr_arb
    import nou_sched_pkg::*;
(
    input  logic [NOU_REQ_CLS_NUM-1:0] pending,
    input  nou_cls_e                   rr_ptr,
    output nou_cls_e                   winner,
    output logic                       any_vld
);

    logic [1:0] idx;

    // Walk from the farthest candidate back to rr_ptr so the closest pending class is written last.
    always_comb begin
        winner  = rr_ptr;
        any_vld = 1'b0;
        idx     = '0;
        for (int k = NOU_REQ_CLS_NUM - 1; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (pending[idx]) begin
                winner  = nou_cls_e'(idx);
                any_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nou_req_sched.sv
// Scheduler that collects per-class NOU requests and serialises them onto
// one shared processing engine, with overflow and engine-timeout flags.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | arbitration cycle; latch round-robin winner if anything pends
// ST_ISSUE | eng_vld high, eng_cls stable, waiting for eng_rdy
// ST_WAIT  | engine busy; count cycles until eng_done or timeout
module nou_req_sched
    import nou_sched_pkg::*;
#(
    parameter int TMO_CYC = 200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NOU_REQ_CLS_NUM-1:0] req_vld,
    output logic [NOU_REQ_CLS_NUM-1:0] req_busy,
    output logic                       eng_vld,
    output logic [1:0]                 eng_cls,
    input  logic                       eng_rdy,
    input  logic                       eng_done,
    output logic [NOU_REQ_CLS_NUM-1:0] ovf_err,
    output logic                       tmo_err,
    input  logic                       err_clr
);

    localparam logic [NOU_CNT_W-1:0] TMO_LAST = NOU_CNT_W'(TMO_CYC - 1);

    nou_state_e                 state, state_nxt;
    nou_cls_e                   cls_q, cls_nxt;
    nou_cls_e                   rr_ptr, rr_ptr_nxt;
    nou_cls_e                   win_cls;
    logic                       win_vld;
    logic [NOU_REQ_CLS_NUM-1:0] pending, pending_nxt;
    logic [NOU_REQ_CLS_NUM-1:0] acc_mask;
    logic [NOU_REQ_CLS_NUM-1:0] ovf_set;
    logic [NOU_CNT_W-1:0]       cnt, cnt_nxt;
    logic                       tmo_set;
    logic                       accept;

    nou_rr_arb u_rr_arb (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .winner  (win_cls),
        .any_vld (win_vld)
    );

    assign eng_vld  = (state == ST_ISSUE);
    assign eng_cls  = cls_q;
    assign req_busy = pending;
    assign accept   = eng_vld & eng_rdy;

    // A request arriving on its own accept edge re-arms pending instead of overflowing.
    always_comb begin
        acc_mask = '0;
        if (accept) begin
            acc_mask[cls_q] = 1'b1;
        end
        ovf_set     = req_vld & pending & ~acc_mask;
        pending_nxt = (pending & ~acc_mask) | req_vld;
    end

    always_comb begin
        state_nxt  = state;
        cls_nxt    = cls_q;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        tmo_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    cls_nxt   = win_cls;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (eng_rdy) begin
                    state_nxt  = ST_WAIT;
                    rr_ptr_nxt = nou_cls_e'(cls_q + 2'd1);
                    cnt_nxt    = '0;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt + 1'b1;
                if (eng_done) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = ST_IDLE;
                    tmo_set   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Error flags: a same-cycle set beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q   <= CLS_IRR;
            rr_ptr  <= CLS_IRR;
            cnt     <= '0;
            pending <= '0;
            ovf_err <= '0;
            tmo_err <= 1'b0;
        end else begin
            cls_q   <= cls_nxt;
            rr_ptr  <= rr_ptr_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            ovf_err <= (err_clr ? '0 : ovf_err) | ovf_set;
            tmo_err <= (err_clr ? 1'b0 : tmo_err) | tmo_set;
        end
    end

endmodule

// File: tb/tb_nou_req_sched.sv
// Self-checking bench for nou_req_sched: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level scheduler model.
module tb_nou_req_sched;

    localparam int TMO = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_vld;
    logic [3:0] req_busy;
    logic       eng_vld;
    logic [1:0] eng_cls;
    logic       eng_rdy;
    logic       eng_done;
    logic [3:0] ovf_err;
    logic       tmo_err;
    logic       err_clr;

    nou_req_sched #(.TMO_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_busy (req_busy),
        .eng_vld  (eng_vld),
        .eng_cls  (eng_cls),
        .eng_rdy  (eng_rdy),
        .eng_done (eng_done),
        .ovf_err  (ovf_err),
        .tmo_err  (tmo_err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: phase 0 = arbitrating, 1 = offering, 2 = engine working
    logic [3:0] m_pend;
    logic [3:0] m_ovf;
    logic       m_tmo;
    int         m_phase;
    int         m_cls;
    int         m_ptr;
    int         m_age;
    int         grants[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_ovf   = '0;
        m_tmo   = 1'b0;
        m_phase = 0;
        m_cls   = 0;
        m_ptr   = 0;
        m_age   = 0;
    endtask

    function automatic int rr_pick(input logic [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] rv, input logic rdy, input logic done, input logic clr);
        logic [3:0] acc;
        logic [3:0] nxt_pend;
        logic       tmo_now;
        int         pick;
        acc     = '0;
        tmo_now = 1'b0;
        if (m_phase == 1 && rdy) acc = 4'(1 << m_cls);
        m_ovf    = (clr ? 4'b0 : m_ovf) | (rv & m_pend & ~acc);
        nxt_pend = (m_pend & ~acc) | rv;
        case (m_phase)
            0: begin
                pick = rr_pick(m_pend, m_ptr);
                if (pick >= 0) begin
                    m_cls   = pick;
                    m_phase = 1;
                end
            end
            1: begin
                if (rdy) begin
                    m_phase = 2;
                    m_ptr   = (m_cls + 1) % 4;
                    m_age   = 0;
                end
            end
            default: begin
                m_age++;
                if (done) begin
                    m_phase = 0;
                end else if (m_age == TMO) begin
                    m_phase = 0;
                    tmo_now = 1'b1;
                end
            end
        endcase
        m_tmo  = (clr ? 1'b0 : m_tmo) | tmo_now;
        m_pend = nxt_pend;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_busy"}, 32'(req_busy), 32'(m_pend));
        check_val({tag, "_vld"},  32'(eng_vld),  32'(m_phase == 1));
        if (m_phase == 1) check_val({tag, "_cls"}, 32'(eng_cls), 32'(m_cls));
        check_val({tag, "_ovf"},  32'(ovf_err),  32'(m_ovf));
        check_val({tag, "_tmo"},  32'(tmo_err),  32'(m_tmo));
    endtask

    // Called at a falling edge; drives inputs, advances one rising edge, checks at the next falling edge.
    task automatic step(input logic [3:0] rv, input logic rdy, input logic done, input logic clr, input string tag);
        req_vld  = rv;
        eng_rdy  = rdy;
        eng_done = done;
        err_clr  = clr;
        #1;
        if (eng_vld && rdy) grants.push_back(int'(eng_cls));
        @(posedge clk);
        model_edge(rv, rdy, done, clr);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        req_vld  = '0;
        eng_rdy  = 1'b0;
        eng_done = 1'b0;
        err_clr  = 1'b0;
        rst      = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        check_val({tag, "_cls0"}, 32'(eng_cls), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        grants.delete();
    endtask

    initial begin
        int since;
        logic d;
        int ng;

        rst = 1'b1;
        @(negedge clk);
        do_reset("rst0");

        // Single BRR request: offer at cycle 2, accept at cycle 4, busy drops at cycle 5
        step(4'b0010, 1'b0, 1'b0, 1'b0, "s33");
        check_val("s33_busy1", 32'(req_busy), 32'b0010);
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s33");
        check_val("s33_vld", 32'(eng_vld), 32'd1);
        check_val("s33_cls", 32'(eng_cls), 32'd1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s33");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s33");
        step(4'b0000, 1'b1, 1'b0, 1'b0, "s33");
        check_val("s33_busy5", 32'(req_busy[1]), 32'd0);

        // All four classes at once, engine always ready, done two cycles after accept
        do_reset("rst34");
        since = -1;
        for (int i = 0; i < 40; i++) begin
            d  = (since == 2);
            ng = grants.size();
            step((i == 0) ? 4'b1111 : 4'b0000, 1'b1, d, 1'b0, "s34");
            if (grants.size() != ng) since = 0;
            else if (d)              since = -1;
            else if (since >= 0)     since++;
        end
        check_val("s34_ngrant", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check_val("s34_order", 32'(grants[i]), 32'(i));
        end
        grants.delete();
        since = -1;
        for (int i = 0; i < 8; i++) begin
            d  = (since == 2);
            ng = grants.size();
            step((i == 0) ? 4'b0001 : 4'b0000, 1'b1, d, 1'b0, "s34b");
            if (grants.size() != ng) since = 0;
            else if (d)              since = -1;
            else if (since >= 0)     since++;
        end
        check_val("s34_lone_n", 32'(grants.size()), 32'd1);
        if (grants.size() > 0) check_val("s34_lone_cls", 32'(grants[0]), 32'd0);

        // PWRR requested twice before grant: one overflow, one grant
        do_reset("rst35");
        step(4'b0100, 1'b0, 1'b0, 1'b0, "s35");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s35");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s35");
        step(4'b0100, 1'b0, 1'b0, 1'b0, "s35");
        check_val("s35_ovf", 32'(ovf_err), 32'b0100);
        for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b1, 1'b0, "s35");
        check_val("s35_ngrant", 32'(grants.size()), 32'd1);
        step(4'b0000, 1'b0, 1'b0, 1'b1, "s35");
        check_val("s35_clr", 32'(ovf_err), 32'd0);

        // Engine never finishes: timeout exactly TMO cycles after accept, then next class issues
        do_reset("rst36");
        step(4'b0001, 1'b0, 1'b0, 1'b0, "s36");
        step(4'b0100, 1'b0, 1'b0, 1'b0, "s36");
        step(4'b0000, 1'b1, 1'b0, 1'b0, "s36");
        for (int i = 0; i < TMO - 1; i++) step(4'b0000, 1'b0, 1'b0, 1'b0, "s36");
        check_val("s36_tmo_early", 32'(tmo_err), 32'd0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s36");
        check_val("s36_tmo", 32'(tmo_err), 32'd1);
        check_val("s36_idle", 32'(eng_vld), 32'd0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s36");
        check_val("s36_next_vld", 32'(eng_vld), 32'd1);
        check_val("s36_next_cls", 32'(eng_cls), 32'd2);

        // Reset in WAIT with SPRR pending: everything silently dropped
        do_reset("rst37a");
        step(4'b1000, 1'b0, 1'b0, 1'b0, "s37");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s37");
        step(4'b0000, 1'b1, 1'b0, 1'b0, "s37");
        step(4'b1000, 1'b0, 1'b0, 1'b0, "s37");
        check_val("s37_pend", 32'(req_busy), 32'b1000);
        do_reset("s37_rst");
        check_val("s37_zero", 32'({req_busy, eng_vld, eng_cls, ovf_err, tmo_err}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b1, 1'b0, 1'b0, "s37");
            check_val("s37_quiet", 32'(eng_vld), 32'd0);
        end

        // IRR re-request on its own accept edge
        do_reset("rst38");
        step(4'b0001, 1'b0, 1'b0, 1'b0, "s38");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s38");
        step(4'b0001, 1'b1, 1'b0, 1'b0, "s38");
        check_val("s38_pend", 32'(req_busy[0]), 32'd1);
        check_val("s38_ovf", 32'(ovf_err[0]), 32'd0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s38");
        step(4'b0000, 1'b0, 1'b1, 1'b0, "s38");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "s38");
        check_val("s38_revld", 32'(eng_vld), 32'd1);
        check_val("s38_recls", 32'(eng_cls), 32'd0);

        // Random traffic against the model
        do_reset("rst_rnd");
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0),
                 "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nou_req_sched.md
NOU_REQ_SCHED -- requirements
Module: nou_req_sched

Interface
REQ-001 Parameter TMO_CYC, default 200: cycles allowed between engine accept and eng_done before a timeout; legal range 1..255.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_vld  in  4  registered request-valid pulses; bit0 IRR, bit1 BRR, bit2 PWRR, bit3 SPRR.
REQ-005 req_busy  out  4  per-class pending flag; upstream holds off new requests of a class while its bit is set.
REQ-006 eng_vld  out  1  request offered to the shared NOU processing engine.
REQ-007 eng_cls  out  2  class of the offered request; also the payload-mux select.
REQ-008 eng_rdy  in  1  engine accepts the offer.
REQ-009 eng_done  in  1  one-cycle pulse; the engine finished the accepted request.
REQ-010 ovf_err  out  4  sticky per-class overflow: request dropped.
REQ-011 tmo_err  out  1  sticky engine timeout.
REQ-012 err_clr  in  1  clears ovf_err and tmo_err.

Function
REQ-013 pending[i] SHALL set on the edge after req_vld[i]=1 and SHALL clear on the edge where its class is accepted (eng_vld & eng_rdy & eng_cls==i).
REQ-014 req_vld[i] on the accept edge of class i SHALL leave pending[i]=1 with no error.
REQ-015 req_vld[i] while pending[i]=1 and not being accepted SHALL drop the request and set ovf_err[i].
REQ-016 req_busy SHALL equal pending.
REQ-017 FSM states IDLE, ISSUE, WAIT.
REQ-018 IDLE: if any pending bit is set, latch the round-robin winner into eng_cls and go to ISSUE; otherwise stay in IDLE.
REQ-019 Round-robin search SHALL start at rr_ptr and proceed upward modulo 4.
REQ-020 ISSUE: eng_vld=1 and eng_cls held stable; on eng_rdy go to WAIT, set rr_ptr=(eng_cls+1) mod 4 and clear the counter.
REQ-021 WAIT: eng_vld=0; the 8-bit counter increments each cycle.
REQ-022 WAIT: eng_done SHALL return the FSM to IDLE.
REQ-023 WAIT: counter==TMO_CYC-1 without eng_done SHALL set tmo_err and return the FSM to IDLE.
REQ-024 eng_done in IDLE or ISSUE SHALL be ignored.
REQ-025 Minimum latency: req_vld at cycle 0 -> pending at cycle 1 -> eng_vld at cycle 2.
REQ-026 After eng_done, the next eng_vld SHALL follow one cycle later at the earliest (IDLE arbitration cycle).
REQ-027 err_clr and a new error event in the same cycle: the error SHALL win and remain set.
REQ-028 Outputs other than eng_vld SHALL be registered; eng_vld SHALL be decoded from state==ISSUE.

Reset
REQ-029 While rst=1: state=IDLE, pending=0, rr_ptr=0, counter=0, eng_cls=0, eng_vld=0, req_busy=0, ovf_err=0, tmo_err=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the request silently; no error flag is set.

Structure
REQ-031 Package nou_sched_pkg SHALL hold NOU_REQ_CLS_NUM=4, the class enum (IRR/BRR/PWRR/SPRR), the FSM state enum and the counter width.
REQ-032 Sub-module nou_rr_arb SHALL hold the 4-way combinational round-robin pick from (pending, rr_ptr), returning the winner index and an any-valid flag.

Verification
REQ-033 req_vld=4'b0010 at cycle 0 -> eng_vld=1, eng_cls=1 at cycle 2; eng_rdy at cycle 4 -> req_busy[1]=0 at cycle 5.
REQ-034 req_vld=4'b1111 together, engine always ready, eng_done 2 cycles after accept -> grant order 0,1,2,3; afterward a lone req_vld[0] is granted next.
REQ-035 req_vld[2] twice, 3 cycles apart, before grant -> ovf_err=4'b0100, one grant only; err_clr -> ovf_err=0.
REQ-036 TMO_CYC=10, accept then no eng_done -> tmo_err=1 exactly 10 cycles after accept edge, FSM in IDLE, next pending request is issued.
REQ-037 rst asserted during WAIT with class 3 pending -> all outputs 0 immediately, no eng_vld after release until a new req_vld.
REQ-038 req_vld[0] on the accept edge of class 0 -> pending[0] remains 1, ovf_err[0]=0, class 0 re-offered after eng_done.
